prog_feeder: RTL and testbench

- Instruction source for simple_proc. It holds a small loadable program memory and drives the processor's 9-bit din port in lock-step with the processor's one-hot tick.
- It presents each instruction word during the tick that loads IR. For MOVI/ADDI it then presents the following immediate word for the rest of that instruction.
- It advances the PC, detects HALT, and reports busy/done to the top level (DE10-lite wrapper or testbench).

---
 rtl/prog_feeder_pkg.sv | 16 +
 rtl/prog_mem.sv | 17 +
 rtl/prog_feeder.sv | 69 ++++++
 tb/tb_prog_feeder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/prog_feeder_pkg.sv
// prog_feeder_pkg: opcodes, one-hot tick codes and feeder state encoding
package prog_feeder_pkg;
  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MOVI = 3'b111;
  localparam logic [3:0] T0 = 4'b0001;
  localparam logic [3:0] T1 = 4'b0010;
  localparam logic [3:0] T2 = 4'b0100;
  localparam logic [3:0] T3 = 4'b1000;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_IMM, S_HALT} state_t;
  function automatic logic has_imm(input logic [2:0] op);
    return op == OP_ADDI || op == OP_MOVI;
  endfunction
endpackage

// File: rtl/prog_mem.sv
// prog_mem: DEPTH x 9 program store, synchronous write, asynchronous read
module prog_mem #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [8:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [8:0]        rdata
);
  logic [8:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_feeder.sv
// prog_feeder: steps a loaded program onto simple_proc's din in lock-step with its tick
module prog_feeder
  import prog_feeder_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [8:0]        wr_data,
  input  logic              run,
  input  logic [3:0]        tick,
  output logic [8:0]        din,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc_n, pc_inc;
  logic [8:0] word;
  logic [2:0] op;
  prog_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (wr_en && !busy),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(pc),
    .rdata(word)
  );
  assign op     = word[8:6];
  assign pc_inc = pc + ADDR_W'(1);
  assign busy   = state == S_FETCH || state == S_IMM;
  assign done   = state == S_HALT;
  assign din    = busy ? word : 9'h000;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  always_comb begin
    state_n = state;
    pc_n    = pc;
    case (state)
      S_IDLE:
        if (run) begin
          state_n = S_FETCH;
          pc_n    = '0;
        end
      S_FETCH:
        if (tick == T0) begin
          state_n = op == OP_HALT ? S_HALT : has_imm(op) ? S_IMM : S_FETCH;
          pc_n    = op == OP_HALT ? pc : pc_inc;
        end else if (!run) state_n = S_IDLE;
      S_IMM:
        if (tick == T3) begin
          state_n = S_FETCH;
          pc_n    = pc_inc;
        end
      S_HALT:
        if (!run) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_prog_feeder.sv
// tb_prog_feeder: directed program scenarios plus random stimulus against a behavioural model
module tb_prog_feeder;
  localparam int M_IDLE = 0, M_FETCH = 1, M_IMM = 2, M_HALT = 3;
  logic clk = 0, rst, wr_en, run;
  logic [3:0] wr_addr, tick, pc;
  logic [8:0] wr_data, din;
  logic busy, done;
  int n_pass = 0, n_chk = 0;
  logic [8:0] m_mem [16];
  int m_st = M_IDLE;
  logic [3:0] m_pc = 0;
  int tp = 0;
  logic [8:0] seq [$];

  always #5 clk = ~clk;

  prog_feeder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .tick(tick), .din(din), .pc(pc), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int words(input logic [8:0] w);
    return (w[8:6] == 3'b010 || w[8:6] == 3'b111) ? 2 : 1;
  endfunction

  task automatic next_tick();
    tick = 4'b0001 << tp;
    tp = (tp + 1) % 4;
  endtask

  task automatic step();
    int ns = m_st;
    logic [3:0] np = m_pc;
    logic [8:0] w = m_mem[m_pc];
    if (rst) begin
      ns = M_IDLE;
      np = 0;
    end else if (m_st == M_IDLE) begin
      if (run) begin ns = M_FETCH; np = 0; end
    end else if (m_st == M_FETCH) begin
      if (tick == 4'b0001) begin
        if (w[8:6] == 3'b000) ns = M_HALT;
        else begin
          np = m_pc + 4'd1;
          ns = words(w) == 2 ? M_IMM : M_FETCH;
        end
      end else if (!run) ns = M_IDLE;
    end else if (m_st == M_IMM) begin
      if (tick == 4'b1000) begin ns = M_FETCH; np = m_pc + 4'd1; end
    end else if (!run) ns = M_IDLE;
    if (wr_en && (m_st == M_IDLE || m_st == M_HALT)) m_mem[wr_addr] = wr_data;
    m_st = ns;
    m_pc = np;
    @(posedge clk);
    #1;
    check("pc", 16'(pc), 16'(m_pc));
    check("busy", 16'(busy), 16'(m_st == M_FETCH || m_st == M_IMM));
    check("done", 16'(done), 16'(m_st == M_HALT));
    check("din", 16'(din), (m_st == M_FETCH || m_st == M_IMM) ? 16'(m_mem[m_pc]) : 16'h0);
  endtask

  task automatic load(input logic [8:0] prog [16]);
    run = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = prog[i];
      step();
    end
    wr_en = 0;
  endtask

  task automatic run_prog(input logic wr_busy);
    int cyc = 0;
    seq.delete();
    run = 1;
    while (m_st != M_HALT && cyc < 200) begin
      next_tick();
      wr_en = wr_busy && (m_st == M_FETCH || m_st == M_IMM);
      wr_addr = 4'd2; wr_data = 9'h1FF;
      if (m_st == M_FETCH && tick == 4'b0001) seq.push_back(din);
      step();
      cyc++;
    end
    wr_en = 0;
    check("halt_reached", 16'(done), 16'h1);
  endtask

  task automatic check_seq();
    logic [8:0] exp [4] = '{9'h1C8, 9'h088, 9'h049, 9'h000};
    check("seq_len", 16'(seq.size()), 16'd4);
    for (int i = 0; i < 4 && i < seq.size(); i++) check("seq_word", 16'(seq[i]), 16'(exp[i]));
  endtask

  initial begin
    logic [8:0] prog [16];
    logic [3:0] hold_pc;
    int cyc;
    rst = 1; run = 0; wr_en = 0; wr_addr = 0; wr_data = 0; tick = 0;
    step();
    check("rst_pc", 16'(pc), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_din", 16'(din), 16'h0);
    rst = 0;
    prog = '{9'h1C8, 9'h005, 9'h088, 9'h003, 9'h049, 9'h000,
             9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    load(prog);
    tp = 0;
    run_prog(0);
    check_seq();
    check("halt_pc", 16'(pc), 16'h5);
    run = 0; tick = 0; step();
    check("halt_to_idle", 16'(done), 16'h0);
    tp = 0;
    run_prog(1);
    check_seq();
    check("busy_write_ignored", 16'(m_mem[2]), 16'h088);
    wr_en = 1; wr_addr = 2; wr_data = 9'h1FF; step();
    wr_en = 0;
    run = 0; tick = 0; step();
    run = 1; tp = 0; cyc = 0;
    while (!(m_st == M_FETCH && m_pc == 2) && cyc < 50) begin next_tick(); step(); cyc++; end
    check("halt_write_din", 16'(din), 16'h1FF);
    run = 0; tick = 0; step(); step();
    run = 1; tp = 0; cyc = 0;
    while (!(m_st == M_IMM && m_pc == 1) && cyc < 50) begin next_tick(); step(); cyc++; end
    rst = 1; step(); rst = 0;
    check("rstimm_pc", 16'(pc), 16'h0);
    check("rstimm_busy", 16'(busy), 16'h0);
    check("rstimm_din", 16'(din), 16'h0);
    check("rstimm_mem1", 16'(m_mem[1]), 16'h005);
    for (int i = 0; i < 15; i++) prog[i] = 9'h049;
    prog[15] = 9'h1C8;
    load(prog);
    run = 1; tp = 0; cyc = 0;
    while (!(m_st == M_IMM && m_pc == 0) && cyc < 200) begin next_tick(); step(); cyc++; end
    check("wrap_imm_din", 16'(din), 16'h049);
    while (m_st == M_IMM && cyc < 200) begin next_tick(); step(); cyc++; end
    check("wrap_pc", 16'(pc), 16'h1);
    hold_pc = pc;
    for (int i = 0; i < 8; i++) begin tick = (i % 2) ? 4'b0011 : 4'b0000; step(); end
    check("bad_tick_pc", 16'(pc), 16'(hold_pc));
    check("bad_tick_busy", 16'(busy), 16'h1);
    run = 0; tick = 0; step();
    check("drop_fetch_busy", 16'(busy), 16'h0);
    check("drop_fetch_pc", 16'(pc), 16'(hold_pc));
    for (int i = 0; i < 2000; i++) begin
      rst = $urandom_range(0, 99) == 0;
      run = $urandom_range(0, 9) != 0;
      wr_en = $urandom_range(0, 9) == 0;
      wr_addr = 4'($urandom);
      wr_data = 9'($urandom);
      if ($urandom_range(0, 9) < 8) next_tick();
      else tick = 4'($urandom);
      step();
    end
    rst = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
